// File: rtl/bus_arbiter_pkg.sv
// Shared encodings and widths for the two-master north-bridge port arbiter.
package bus_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int WE_W   = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

endpackage

// File: rtl/bus_rr_pick.sv
// Winner selection between master 0 and master 1: fixed priority or
// round-robin against the previous owner. Purely combinational.
module bus_rr_pick
  import bus_arbiter_pkg::*;
#(
  parameter int FIXED_PRIORITY = 0
) (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic [1:0] pick
);

  // One-hot pick; on a tie the master that did not own the bus last wins
  // unless master 0 has fixed priority.
  always_comb begin
    pick = GNT_NONE;
    case (req)
      2'b01:   pick = GNT_M0;
      2'b10:   pick = GNT_M1;
      2'b11: begin
        if (FIXED_PRIORITY != 0) pick = GNT_M0;
        else                     pick = last_owner ? GNT_M0 : GNT_M1;
      end
      default: pick = GNT_NONE;
    endcase
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master arbiter for the north bridge CPU-side data port. Serialises
// master 0 (CPU) and master 1 (DMA), stretches each transaction by
// WAIT_CYCLES, strobes the write enables once in the last access cycle and
// returns registered read data with a one-cycle acknowledge.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int WAIT_CYCLES    = 1,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [WE_W-1:0]   m0_we,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [WE_W-1:0]   m1_we,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [WE_W-1:0]   bus_we,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic [1:0]        grant
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              last_owner;   // 0 = master 0, 1 = master 1
  logic              owner;        // owner of the transaction in flight
  logic [WE_W-1:0]   we_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        pick;
  logic              pick_m1;

  bus_rr_pick #(
    .FIXED_PRIORITY(FIXED_PRIORITY)
  ) u_pick (
    .req        ({m1_req, m0_req}),
    .last_owner (last_owner),
    .pick       (pick)
  );

  assign pick_m1 = pick[1];

  // Transaction FSM; every bridge-facing and ack output is registered here so
  // the bridge sees clean, glitch-free signals.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      last_owner <= 1'b1;
      owner      <= 1'b0;
      we_q       <= '0;
      rdata_q    <= '0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_we     <= '0;
      grant      <= GNT_NONE;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick != GNT_NONE) begin
            // The bus address/data registers double as the transaction
            // latch: nothing from the masters is looked at again until IDLE.
            owner     <= pick_m1;
            we_q      <= pick_m1 ? m1_we : m0_we;
            bus_addr  <= pick_m1 ? m1_addr : m0_addr;
            bus_wdata <= pick_m1 ? m1_wdata : m0_wdata;
            bus_we    <= (CNT_LOAD == '0) ? (pick_m1 ? m1_we : m0_we) : '0;
            cnt       <= CNT_LOAD;
            grant     <= pick;
            state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (cnt != '0) begin
            cnt    <= cnt - 1'b1;
            // Raise the strobe only for the cycle in which cnt will be zero.
            bus_we <= (cnt == CNT_W'(1)) ? we_q : '0;
          end else begin
            rdata_q <= bus_rdata;
            bus_we  <= '0;
            m0_ack  <= ~owner;
            m1_ack  <= owner;
            state   <= ST_RESP;
          end
        end
        ST_RESP: begin
          m0_ack     <= 1'b0;
          m1_ack     <= 1'b0;
          last_owner <= owner;
          grant      <= GNT_NONE;
          bus_addr   <= '0;
          bus_wdata  <= '0;
          bus_we     <= '0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign m0_rdata = m0_ack ? rdata_q : '0;
  assign m1_rdata = m1_ack ? rdata_q : '0;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: instance A (WAIT_CYCLES=1, round-robin) and
// instance B (WAIT_CYCLES=2, fixed priority), a table of transactions plus
// hand-written multi-cycle sequences, and an ack scoreboard per instance.
module tb_bus_arbiter;

  localparam int WA = 1;
  localparam int WB = 2;

  logic        clk = 1'b0;
  logic        reset_n;

  logic        a_m0_req, a_m1_req, b_m0_req, b_m1_req;
  logic [31:0] a_m0_addr, a_m0_wdata, a_m1_addr, a_m1_wdata;
  logic [31:0] b_m0_addr, b_m0_wdata, b_m1_addr, b_m1_wdata;
  logic [3:0]  a_m0_we, a_m1_we, b_m0_we, b_m1_we;
  logic        a_m0_ack, a_m1_ack, b_m0_ack, b_m1_ack;
  logic [31:0] a_m0_rdata, a_m1_rdata, b_m0_rdata, b_m1_rdata;
  logic [31:0] a_bus_addr, a_bus_wdata, a_bus_rdata;
  logic [31:0] b_bus_addr, b_bus_wdata, b_bus_rdata;
  logic [3:0]  a_bus_we, b_bus_we;
  logic [1:0]  a_grant, b_grant;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        who;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];

  typedef struct {
    logic        r0, r1;
    logic [31:0] a0, d0;
    logic [3:0]  w0;
    logic [31:0] a1, d1;
    logic [3:0]  w1;
    int          n;
    logic [3:0]  win;   // bit i = master expected to win transaction i
  } vec_t;

  always #5 clk = ~clk;

  // Bridge model: read data is a fixed function of the address.
  function automatic logic [31:0] bridge_rd(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  assign a_bus_rdata = bridge_rd(a_bus_addr);
  assign b_bus_rdata = bridge_rd(b_bus_addr);

  bus_arbiter #(.WAIT_CYCLES(WA), .FIXED_PRIORITY(0)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .m0_req(a_m0_req), .m0_addr(a_m0_addr), .m0_wdata(a_m0_wdata), .m0_we(a_m0_we),
    .m0_ack(a_m0_ack), .m0_rdata(a_m0_rdata),
    .m1_req(a_m1_req), .m1_addr(a_m1_addr), .m1_wdata(a_m1_wdata), .m1_we(a_m1_we),
    .m1_ack(a_m1_ack), .m1_rdata(a_m1_rdata),
    .bus_addr(a_bus_addr), .bus_wdata(a_bus_wdata), .bus_we(a_bus_we),
    .bus_rdata(a_bus_rdata), .grant(a_grant)
  );

  bus_arbiter #(.WAIT_CYCLES(WB), .FIXED_PRIORITY(1)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .m0_req(b_m0_req), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata), .m0_we(b_m0_we),
    .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata),
    .m1_req(b_m1_req), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata), .m1_we(b_m1_we),
    .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata),
    .bus_addr(b_bus_addr), .bus_wdata(b_bus_wdata), .bus_we(b_bus_we),
    .bus_rdata(b_bus_rdata), .grant(b_grant)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard side: every ack pops one expected record.
  task automatic mon(input bit sel);
    logic        k0, k1;
    logic [31:0] r0, r1;
    exp_t        e;
    string       p;
    int          depth;
    k0    = sel ? b_m0_ack : a_m0_ack;
    k1    = sel ? b_m1_ack : a_m1_ack;
    r0    = sel ? b_m0_rdata : a_m0_rdata;
    r1    = sel ? b_m1_rdata : a_m1_rdata;
    p     = sel ? "b" : "a";
    depth = sel ? sb_b.size() : sb_a.size();
    if (!k0) chk({p, "_m0_rdata_idle"}, r0, 32'h0);
    if (!k1) chk({p, "_m1_rdata_idle"}, r1, 32'h0);
    if (k0 || k1) begin
      if (depth == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_unexpected_ack: got ack=%b%b, required none", p, k1, k0);
      end else begin
        if (sel) e = sb_b.pop_front();
        else     e = sb_a.pop_front();
        chk({p, "_ack_vec"}, 32'({k1, k0}), e.who ? 32'd2 : 32'd1);
        chk({p, "_ack_rdata"}, e.who ? r1 : r0, e.rdata);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon(1'b0);
    mon(1'b1);
  endtask

  task automatic set_req(input bit sel, input bit m, input logic v);
    if (sel) begin
      if (m) b_m1_req = v; else b_m0_req = v;
    end else begin
      if (m) a_m1_req = v; else a_m0_req = v;
    end
  endtask

  // Runs n back-to-back transactions whose requests the caller has just
  // raised in IDLE, checking grant / strobe / address / ack timing per cycle.
  task automatic run(input bit sel, input int n, input logic [3:0] win, input bit mutate);
    int          w, per, j, o;
    int          left [2];
    logic [31:0] ca [2];
    logic [31:0] cd [2];
    logic [3:0]  cw [2];
    logic        who;
    logic [1:0]  eg, ea, g, ack;
    logic [3:0]  ewe, bwe;
    logic [31:0] ba, bd;
    exp_t        e;
    w     = sel ? WB : WA;
    per   = w + 3;
    ca[0] = sel ? b_m0_addr  : a_m0_addr;
    ca[1] = sel ? b_m1_addr  : a_m1_addr;
    cd[0] = sel ? b_m0_wdata : a_m0_wdata;
    cd[1] = sel ? b_m1_wdata : a_m1_wdata;
    cw[0] = sel ? b_m0_we    : a_m0_we;
    cw[1] = sel ? b_m1_we    : a_m1_we;
    left[0] = 0;
    left[1] = 0;
    for (int i = 0; i < n; i++) begin
      left[win[i]]++;
      e.who   = win[i];
      e.rdata = bridge_rd(ca[win[i]]);
      if (sel) sb_b.push_back(e); else sb_a.push_back(e);
    end
    for (int k = 1; k <= n * per; k++) begin
      tick();
      j   = (k - 1) / per;
      o   = k - j * per;
      who = win[j];
      eg  = (o <= w + 2) ? (who ? 2'b10 : 2'b01) : 2'b00;
      ea  = (o == w + 2) ? eg : 2'b00;
      ewe = (o == w + 1) ? cw[who] : 4'h0;
      g   = sel ? b_grant : a_grant;
      ack = sel ? {b_m1_ack, b_m0_ack} : {a_m1_ack, a_m0_ack};
      bwe = sel ? b_bus_we : a_bus_we;
      ba  = sel ? b_bus_addr : a_bus_addr;
      bd  = sel ? b_bus_wdata : a_bus_wdata;
      chk("grant", 32'(g), 32'(eg));
      chk("ack_timing", 32'(ack), 32'(ea));
      chk("bus_we", 32'(bwe), 32'(ewe));
      if (o <= w + 1) begin
        chk("bus_addr", ba, ca[who]);
        chk("bus_wdata", bd, cd[who]);
      end else if (o == w + 3) begin
        chk("bus_addr_idle", ba, 32'h0);
      end
      if (ack[0]) begin
        left[0]--;
        if (left[0] <= 0) set_req(sel, 1'b0, 1'b0);
      end
      if (ack[1]) begin
        left[1]--;
        if (left[1] <= 0) set_req(sel, 1'b1, 1'b0);
      end
      if (mutate && k == 1) begin
        a_m0_addr  = 32'hFFFF0000;
        a_m0_wdata = 32'hFFFFFFFF;
        a_m0_we    = 4'hF;
      end
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_a_grant"}, 32'(a_grant), 32'h0);
    chk({name, "_a_bus_addr"}, a_bus_addr, 32'h0);
    chk({name, "_a_bus_wdata"}, a_bus_wdata, 32'h0);
    chk({name, "_a_bus_we"}, 32'(a_bus_we), 32'h0);
    chk({name, "_a_acks"}, 32'({a_m1_ack, a_m0_ack}), 32'h0);
    chk({name, "_b_grant"}, 32'(b_grant), 32'h0);
    chk({name, "_b_bus_addr"}, b_bus_addr, 32'h0);
    chk({name, "_b_bus_wdata"}, b_bus_wdata, 32'h0);
    chk({name, "_b_bus_we"}, 32'(b_bus_we), 32'h0);
    chk({name, "_b_acks"}, 32'({b_m1_ack, b_m0_ack}), 32'h0);
  endtask

  initial begin
    vec_t vecs [5];
    vecs[0] = '{1'b1, 1'b0, 32'h10,  32'h0,        4'h0, 32'h0,    32'h0,        4'h0, 1, 4'b0000};
    vecs[1] = '{1'b0, 1'b1, 32'h0,   32'h0,        4'h0, 32'h7F00, 32'h12345678, 4'hF, 1, 4'b0001};
    vecs[2] = '{1'b1, 1'b1, 32'h100, 32'h11110000, 4'h0, 32'h200,  32'h22220000, 4'h0, 2, 4'b0010};
    vecs[3] = '{1'b1, 1'b0, 32'h300, 32'hCAFEF00D, 4'h3, 32'h0,    32'h0,        4'h0, 1, 4'b0000};
    vecs[4] = '{1'b1, 1'b1, 32'h400, 32'h0,        4'h0, 32'h500,  32'h55AA55AA, 4'hC, 2, 4'b0001};

    reset_n  = 1'b0;
    a_m0_req = 1'b0; a_m1_req = 1'b0; b_m0_req = 1'b0; b_m1_req = 1'b0;
    a_m0_addr = '0; a_m0_wdata = '0; a_m0_we = '0;
    a_m1_addr = '0; a_m1_wdata = '0; a_m1_we = '0;
    b_m0_addr = '0; b_m0_wdata = '0; b_m0_we = '0;
    b_m1_addr = '0; b_m1_wdata = '0; b_m1_we = '0;
    tick();
    tick();
    chk_all_zero("reset");
    reset_n = 1'b1;
    tick();

    // Table: single read, single write, ties under round-robin.
    for (int v = 0; v < 5; v++) begin
      a_m0_addr = vecs[v].a0; a_m0_wdata = vecs[v].d0; a_m0_we = vecs[v].w0;
      a_m1_addr = vecs[v].a1; a_m1_wdata = vecs[v].d1; a_m1_we = vecs[v].w1;
      a_m0_req  = vecs[v].r0; a_m1_req = vecs[v].r1;
      run(1'b0, vecs[v].n, vecs[v].win, 1'b0);
    end

    // Both masters hold req: ownership alternates (m0 was last owner).
    a_m0_addr = 32'h700; a_m0_wdata = 32'h0; a_m0_we = 4'h0;
    a_m1_addr = 32'h780; a_m1_wdata = 32'h0; a_m1_we = 4'h0;
    a_m0_req = 1'b1; a_m1_req = 1'b1;
    run(1'b0, 4, 4'b0101, 1'b0);

    // Master 0 inputs change during ACCESS; latched values must be used.
    a_m0_addr = 32'h600; a_m0_wdata = 32'h11112222; a_m0_we = 4'h0;
    a_m0_req  = 1'b1;
    run(1'b0, 1, 4'b0000, 1'b1);
    a_m0_addr = 32'h0; a_m0_wdata = 32'h0; a_m0_we = 4'h0;

    // Fixed priority: m0 keeps re-requesting, m1 only wins after m0 stops.
    b_m0_addr = 32'h800; b_m0_wdata = 32'h0;        b_m0_we = 4'h0;
    b_m1_addr = 32'h900; b_m1_wdata = 32'h99990001; b_m1_we = 4'h1;
    b_m0_req = 1'b1; b_m1_req = 1'b1;
    run(1'b1, 4, 4'b1000, 1'b0);

    // Reset during the first ACCESS cycle of a WAIT_CYCLES=2 write.
    b_m1_addr = 32'hA00; b_m1_wdata = 32'h0BADCAFE; b_m1_we = 4'hF;
    b_m1_req  = 1'b1;
    tick();
    chk("rst_pre_grant", 32'(b_grant), 32'h2);
    chk("rst_pre_we", 32'(b_bus_we), 32'h0);
    #1 reset_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    b_m1_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_hold_we", 32'(b_bus_we), 32'h0);
      chk("rst_hold_grant", 32'(b_grant), 32'h0);
    end
    reset_n = 1'b1;

    // last_owner returns to master 1 after reset, so master 0 wins this tie.
    a_m0_addr = 32'h10; a_m1_addr = 32'h20;
    a_m0_req = 1'b1; a_m1_req = 1'b1;
    run(1'b0, 2, 4'b0010, 1'b0);
    tick();
    chk_all_zero("end_idle");

    chk("sb_a_drained", 32'(sb_a.size()), 32'h0);
    chk("sb_b_drained", 32'(sb_b.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
